conv_accum: RTL and testbench

- Accumulate stage directly downstream of the signed 8x8 multiplier in the convolution MAC path.
- Takes the multiplier's sign-extended 32-bit products, sums N_TERMS of them onto a per-window bias, then requantizes the sum to a signed 8-bit activation.
- Requantize = rounding arithmetic right shift, optional ReLU, saturation.
- Result feeds the feature-map writeback.

---
 rtl/conv_pkg.sv | 16 +
 rtl/conv_accum_if.sv | 26 ++
 rtl/requant_sat.sv | 43 ++++
 rtl/conv_accum.sv | 87 ++++++++
 tb/tb_conv_accum.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution MAC accumulate/requantize path.
// Pure declarations; no logic, no latency.
package conv_pkg;

   localparam int ACC_W = 32;
   localparam int Q_W   = 8;
   localparam int Q_MAX = 127;
   localparam int Q_MIN = -128;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACC   = 2'd1,
      QUANT = 2'd2
   } state_t;

endpackage

// File: rtl/conv_accum_if.sv
// Window control, product stream and result bus between the multiplier, conv_accum and writeback.
// master drives window setup and products; slave (the accumulator) returns status and results.
interface conv_accum_if #(
   parameter int ACC_W = 32
);
   logic                    start;
   logic signed [ACC_W-1:0] bias;
   logic [4:0]              shift;
   logic                    relu_en;
   logic                    prod_valid;
   logic signed [ACC_W-1:0] prod_in;
   logic                    busy;
   logic                    out_valid;
   logic signed [7:0]       d_out;
   logic signed [ACC_W-1:0] acc_out;

   modport master (
      output start, bias, shift, relu_en, prod_valid, prod_in,
      input  busy, out_valid, d_out, acc_out
   );

   modport slave (
      input  start, bias, shift, relu_en, prod_valid, prod_in,
      output busy, out_valid, d_out, acc_out
   );
endinterface

// File: rtl/requant_sat.sv
// Combinational requantizer: round-half-up arithmetic right shift, optional ReLU, saturate to int8.
// Zero latency; no flow control.
module requant_sat
   import conv_pkg::*;
#(
   parameter int ACC_W = conv_pkg::ACC_W
) (
   input  logic signed [ACC_W-1:0] acc,
   input  logic [4:0]              shift,
   input  logic                    relu_en,
   output logic signed [Q_W-1:0]   d_out
);

   localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(Q_MAX);
   localparam logic signed [ACC_W:0] SAT_LO = (ACC_W+1)'(Q_MIN);

   logic signed [ACC_W:0] ext;
   logic signed [ACC_W:0] rnd;
   logic signed [ACC_W:0] sum;
   logic signed [ACC_W:0] r;

   // One extra bit of headroom keeps acc + half-LSB from overflowing.
   always_comb begin
      ext = {acc[ACC_W-1], acc};
      rnd = '0;
      if (shift != 5'd0) begin
         rnd = (ACC_W+1)'(1) << (shift - 5'd1);
      end
      sum = ext + rnd;
      r   = sum >>> shift;
      if (relu_en && r[ACC_W]) begin
         r = '0;
      end
      if (r > SAT_HI) begin
         d_out = Q_W'(Q_MAX);
      end else if (r < SAT_LO) begin
         d_out = Q_W'(Q_MIN);
      end else begin
         d_out = r[Q_W-1:0];
      end
   end

endmodule

// File: rtl/conv_accum.sv
// Sums N_TERMS products onto a bias, then requantizes to int8; out_valid 2 cycles after the last product.
// No backpressure: products are taken whenever prod_valid is high in ACC, start always restarts a window.
module conv_accum #(
   parameter int N_TERMS = 9,
   parameter int ACC_W   = conv_pkg::ACC_W
) (
   input  logic         clk,
   input  logic         rst,
   conv_accum_if.slave  io
);
   import conv_pkg::*;

   state_t                  state;
   state_t                  state_nxt;
   logic signed [ACC_W-1:0] acc;
   logic [7:0]              cnt;
   logic [4:0]              shift_q;
   logic                    relu_q;
   logic                    last_term;
   logic signed [Q_W-1:0]   q_dat;

   assign last_term = io.prod_valid && (cnt == 8'(N_TERMS - 1));
   assign io.busy   = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (io.start) state_nxt = ACC;
         end
         ACC: begin
            if (io.start)       state_nxt = ACC;
            else if (last_term) state_nxt = QUANT;
         end
         QUANT: begin
            state_nxt = io.start ? ACC : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The QUANT-cycle capture reads the old acc/shift_q before a coincident start overwrites them.
   always_ff @(posedge clk) begin
      if (!rst) begin
         acc          <= '0;
         cnt          <= '0;
         shift_q      <= '0;
         relu_q       <= 1'b0;
         io.out_valid <= 1'b0;
         io.d_out     <= '0;
         io.acc_out   <= '0;
      end else begin
         io.out_valid <= (state == QUANT);
         if (state == QUANT) begin
            io.d_out   <= q_dat;
            io.acc_out <= acc;
         end
         if (io.start) begin
            acc     <= io.bias;
            cnt     <= '0;
            shift_q <= io.shift;
            relu_q  <= io.relu_en;
         end else if (state == ACC && io.prod_valid) begin
            acc <= acc + io.prod_in;
            cnt <= cnt + 8'd1;
         end
      end
   end

   requant_sat #(
      .ACC_W (ACC_W)
   ) u_requant (
      .acc     (acc),
      .shift   (shift_q),
      .relu_en (relu_q),
      .d_out   (q_dat)
   );

endmodule

// File: tb/tb_conv_accum.sv
// Randomized and directed bench for conv_accum against a plain-arithmetic reference model.
module tb_conv_accum;
   import conv_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   conv_accum_if #(.ACC_W(ACC_W)) io ();

   conv_accum #(
      .N_TERMS (9),
      .ACC_W   (ACC_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .io  (io.slave)
   );

   int      n_checks = 0;
   int      n_errors = 0;
   longint  model_sum;
   int      model_shift;
   bit      model_relu;
   longint  prods[$];

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint wrap32(input longint v);
      longint w;
      w = v & 64'h0000_0000_FFFF_FFFF;
      if (w >= 64'sh8000_0000) w = w - 64'sh1_0000_0000;
      return w;
   endfunction

   // floor((a + 2^(s-1)) / 2^s), then ReLU and int8 clamp
   function automatic longint ref_q(input longint a, input int s, input bit relu);
      longint num, den, r;
      den = longint'(1) << s;
      num = a + ((s > 0) ? den / 2 : 0);
      r = num / den;
      if ((num % den) != 0 && num < 0) r = r - 1;
      if (relu && r < 0) r = 0;
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      return r;
   endfunction

   task automatic do_start(input longint b, input int s, input bit relu, input bit junk);
      io.start      = 1'b1;
      io.bias       = b[31:0];
      io.shift      = s[4:0];
      io.relu_en    = relu;
      io.prod_valid = junk;
      io.prod_in    = 32'sd12345;
      @(negedge clk);
      io.start      = 1'b0;
      io.prod_valid = 1'b0;
      model_sum     = b;
      model_shift   = s;
      model_relu    = relu;
      check("busy_after_start", longint'(io.busy), 1);
      check("no_out_after_start", longint'(io.out_valid), 0);
   endtask

   task automatic drive_prods(input int gap_mode);
      longint p;
      int     g;
      while (prods.size() > 0) begin
         p = prods.pop_front();
         g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
         repeat (g) begin
            io.prod_valid = 1'b0;
            io.prod_in    = $urandom;
            @(negedge clk);
            check("no_out_in_gap", longint'(io.out_valid), 0);
         end
         io.prod_valid = 1'b1;
         io.prod_in    = p[31:0];
         @(negedge clk);
         model_sum = model_sum + p;
         check("no_out_in_acc", longint'(io.out_valid), 0);
      end
      io.prod_valid = 1'b0;
   endtask

   // Called at the negedge of the QUANT cycle; optionally starts the next window there.
   task automatic expect_result(input string tag, input bit b2b, input longint nb,
                                input int ns, input bit nr);
      longint ea, eq;
      ea = wrap32(model_sum);
      eq = ref_q(ea, model_shift, model_relu);
      check({tag, "_busy_quant"}, longint'(io.busy), 1);
      check({tag, "_early_out"}, longint'(io.out_valid), 0);
      if (b2b) begin
         io.start    = 1'b1;
         io.bias     = nb[31:0];
         io.shift    = ns[4:0];
         io.relu_en  = nr;
         model_sum   = nb;
         model_shift = ns;
         model_relu  = nr;
      end else begin
         io.prod_valid = 1'b1;
         io.prod_in    = $urandom;
      end
      @(negedge clk);
      io.start      = 1'b0;
      io.prod_valid = 1'b0;
      check({tag, "_out_valid"}, longint'(io.out_valid), 1);
      check({tag, "_d_out"}, longint'(io.d_out), eq);
      check({tag, "_acc_out"}, longint'(io.acc_out), ea);
      check({tag, "_busy_after"}, longint'(io.busy), longint'(b2b));
   endtask

   task automatic fill(input int n, input longint v);
      for (int i = 0; i < n; i++) prods.push_back(v);
   endtask

   function automatic longint rnd_prod();
      return (longint'($urandom_range(0, 255)) - 128) * (longint'($urandom_range(0, 255)) - 128);
   endfunction

   function automatic longint rnd_bias();
      if ($urandom_range(0, 3) == 0) return longint'($signed($urandom));
      return longint'($urandom_range(0, 10000)) - 5000;
   endfunction

   initial begin
      bit     started;
      bit     b2b;
      longint nb;
      int     ns;
      bit     nr;

      io.start = 1'b0; io.bias = '0; io.shift = '0; io.relu_en = 1'b0;
      io.prod_valid = 1'b0; io.prod_in = '0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", longint'(io.busy), 0);
      check("rst_out_valid", longint'(io.out_valid), 0);
      check("rst_d_out", longint'(io.d_out), 0);
      check("rst_acc_out", longint'(io.acc_out), 0);
      rst = 1'b1;
      @(negedge clk);

      do_start(0, 3, 0, 0);      fill(9, 100);    drive_prods(0); expect_result("t900", 0, 0, 0, 0);
      do_start(0, 4, 0, 0);      fill(9, 16129);  drive_prods(0); expect_result("satpos", 0, 0, 0, 0);
      do_start(0, 0, 0, 0);      fill(9, -16256); drive_prods(0); expect_result("satneg", 0, 0, 0, 0);
      do_start(0, 0, 1, 0);      fill(9, -16256); drive_prods(0); expect_result("relu", 0, 0, 0, 0);
      do_start(5, 1, 0, 0);      fill(9, 0);      drive_prods(0); expect_result("rnd_pos", 0, 0, 0, 0);
      do_start(-5, 1, 0, 0);     fill(9, 0);      drive_prods(0); expect_result("rnd_neg", 0, 0, 0, 0);
      do_start(2147483632, 31, 0, 0); fill(9, 100); drive_prods(0); expect_result("wrap", 0, 0, 0, 0);

      do_start(0, 0, 0, 0);
      for (int i = 1; i <= 9; i++) prods.push_back(longint'(i));
      drive_prods(1);
      expect_result("gaps", 0, 0, 0, 0);

      do_start(1000, 2, 0, 0);   fill(4, 7);      drive_prods(0);
      do_start(-300, 2, 0, 1);
      for (int i = 0; i < 9; i++) prods.push_back(rnd_prod());
      drive_prods(0);
      expect_result("restart", 0, 0, 0, 0);

      do_start(10, 1, 0, 0);     fill(9, 3);      drive_prods(0);
      expect_result("b2b_first", 1, -50, 2, 1);
      for (int i = 0; i < 9; i++) prods.push_back(rnd_prod());
      drive_prods(2);
      expect_result("b2b_second", 0, 0, 0, 0);

      do_start(77, 0, 0, 0);     fill(5, 11);     drive_prods(0);
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_busy", longint'(io.busy), 0);
      check("mid_rst_out_valid", longint'(io.out_valid), 0);
      check("mid_rst_d_out", longint'(io.d_out), 0);
      check("mid_rst_acc_out", longint'(io.acc_out), 0);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         io.prod_valid = 1'b1;
         io.prod_in    = 32'sd999;
         @(negedge clk);
         check("idle_ignore_busy", longint'(io.busy), 0);
         check("idle_ignore_out", longint'(io.out_valid), 0);
      end
      io.prod_valid = 1'b0;
      do_start(-20, 2, 0, 0);    fill(9, 6);      drive_prods(0); expect_result("post_rst", 0, 0, 0, 0);

      started = 1'b0;
      for (int w = 0; w < 25; w++) begin
         if (!started) do_start(rnd_bias(), int'($urandom_range(0, 31)),
                                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
         for (int i = 0; i < 9; i++) prods.push_back(rnd_prod());
         drive_prods(2);
         b2b = bit'($urandom_range(0, 1));
         nb  = rnd_bias();
         ns  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 12));
         nr  = bit'($urandom_range(0, 1));
         expect_result("rand", b2b, nb, ns, nr);
         started = b2b;
      end
      if (started) begin
         for (int i = 0; i < 9; i++) prods.push_back(rnd_prod());
         drive_prods(0);
         expect_result("rand_tail", 0, 0, 0, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
